instr_fetch_sequencer: RTL

- Sequences the 32-entry, 24-bit instruction ROM of the Full Nibble Processor.
- Holds the program counter and drives the ROM address.
- Absorbs the ROM's one-cycle registered read latency and presents each instruction to decode with a valid/ready handshake.
- Handles branch redirects and halts fetch on the HALT opcode.

---
 rtl/instr_fetch_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer for the Full Nibble Processor.
// Walks the program counter through a 32-word registered-read ROM and hides
// its one-cycle latency. Each fetched word is handed to decode with a
// valid/ready handshake. Also handles branch redirects and the HALT opcode.
module instr_fetch_sequencer #(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF,
  parameter int                    CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  accept_count
);

  // FETCH: ROM samples pc. WAIT: ROM data arrives. VALID: offered to decode.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e                state_q,        state_d;
  logic [ADDR_WIDTH-1:0] pc_q,           pc_d;
  logic [DATA_WIDTH-1:0] instr_q,        instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q,     instr_pc_d;
  logic                  instr_valid_q,  instr_valid_d;
  logic                  halted_q,       halted_d;
  logic [CNT_WIDTH-1:0]  accept_count_q, accept_count_d;

  logic accept;
  logic halt_op;

  assign accept  = (state_q == S_VALID) && instr_ready;
  assign halt_op = (instr_q[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

  // Next-state and next-output computation for the fetch sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = instr_valid_q;
    halted_d       = halted_q;
    accept_count_d = accept_count_q;

    // An accept is counted even when a redirect overrides where pc goes next.
    if (accept && (accept_count_q != {CNT_WIDTH{1'b1}})) begin
      accept_count_d = accept_count_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      S_FETCH: begin
        if (branch_valid) begin
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_valid) begin
          // The word the ROM is returning belongs to the old pc; drop it.
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else begin
          instr_d       = rom_q;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_VALID;
        end
      end
      S_VALID: begin
        if (branch_valid) begin
          pc_d          = branch_target;
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (halt_op) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Register all state; reset overrides everything including HALT.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // that were present before this edge, independent of statement order.
    if (reset) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      accept_count_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      instr_valid_q  <= instr_valid_d;
      halted_q       <= halted_d;
      accept_count_q <= accept_count_d;
    end
  end

  assign rom_addr     = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;
  assign accept_count = accept_count_q;

endmodule
